ahb_slave_mem: RTL
==================

Name: ahb_slave_mem

Overview:
- Memory-backed AHB responder: the slave end of the single-transfer bus driven by our ahb_master.
- Decodes a word-aligned address window, inserts a configurable number of wait states, and completes reads and writes against an internal word array.
- Returns a two-cycle ERROR response for out-of-window or misaligned accesses.
- Sits behind the system address decoder, which drives hsel.

Parameters:
ADDR_W, 6, word-index width; depth = 2**ADDR_W 32-bit words
BASE_ADDR, 32'h0000_0000, window base; must be aligned to the window size (4*2**ADDR_W bytes)
WAIT_STATES, 0, wait cycles inserted before the data cycle; legal range 0..15

Ports:
hclk  input  1  system clock, rising edge
hresetn  input  1  reset, asynchronous, active-high (despite the name)
hsel  input  1  slave select from address decoder
haddr  input  32  byte address from master
hwrite  input  1  1 = write, 0 = read
hready  input  1  master transfer-valid strobe
hwdata  input  32  write data; held by master through the data cycle
hrdata  output  32  read data
hreadyout  output  1  1 = transfer complete / slave free
hresp  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0. Memory contents are not reset.
- Reset mid-transfer: return to IDLE immediately; any pending write is not committed.
- Transfer acceptance: sampled only in IDLE, when hsel & hready at a rising edge. At that edge, latch haddr[ADDR_W+1:2] as the index and hwrite as the direction.
- Error check at acceptance:
  - misaligned: haddr[1:0] != 0
  - out of window: haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]
- Output decode: hreadyout and hresp are Moore outputs decoded from the state. hrdata is registered.
- States:
  - IDLE: hreadyout=1, hresp=0.
    - accept & error -> ERR1
    - accept & ok & WAIT_STATES=0 -> DATA
    - accept & ok & WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1
  - WAIT: hreadyout=0, hresp=0. Counter==0 -> DATA; else decrement.
  - DATA: hreadyout=1, hresp=0, single cycle -> IDLE.
    - Read: hrdata loads mem[index] on the edge entering DATA; valid for the whole DATA cycle, then held until the next read.
    - Write: mem[index] <= hwdata on the edge leaving DATA.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE. hrdata forced to 0 on entry. No memory update.
- Latency, accept to completion: WAIT_STATES+1 cycles for OKAY; 2 cycles for ERROR.
- No pipelined accept: hsel/hready seen in WAIT/DATA/ERR1/ERR2 are ignored. This matches the master, which drops hready after the data cycle.
- hsel or hready deasserting mid-transfer does not abort; the transfer completes.
- Read and write to the same index in consecutive transfers: the read returns the newly written data.

Optional Feature:
- Macro: AHB_SLV_RO_REGION_EN.
- Defined: adds parameter RO_WORDS (default 4). Word indices 0..RO_WORDS-1 are read-only; a write there takes the ERROR path (ERR1/ERR2) and memory is unchanged. Reads there complete OKAY.
- Undefined: all words are writable; no RO_WORDS parameter and no extra logic.

Decomposition:
- Package ahb_slave_pkg:
  - state encoding constants IDLE/WAIT/DATA/ERR1/ERR2 (3-bit)
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1
  - WAIT_CNT_W=4
- Sub-module ahb_slave_regfile: 2**ADDR_W x 32 array with one synchronous write port and one synchronous read port. No reset, so it infers RAM.
- FSM, decode and error logic stay in ahb_slave_mem.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> hreadyout never low; hresp=0; hrdata=0xDEADBEEF in the read DATA cycle.
2. WAIT_STATES=3: read 0x0000_0004 -> hreadyout=0 for exactly 3 cycles after accept, then 1 for one cycle with valid hrdata.
3. Read 0x0000_0102 (misaligned) and write 0x0000_0400 (out of window) -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), hrdata=0; a subsequent read of 0x0000_0000 shows memory unchanged.
4. Assert hresetn during WAIT of a write of 0x12345678 to 0x0000_0020 -> outputs return to reset values immediately; a later read of 0x0000_0020 does not return 0x12345678.
5. Hold hsel=1, hready=1 for 4 consecutive cycles with WAIT_STATES=0 -> accepts at cycles 0 and 2 only; exactly one DATA cycle per accept.
6. AHB_SLV_RO_REGION_EN, RO_WORDS=4: write 0xA5A5A5A5 to 0x0000_0008 -> ERROR response, word unchanged; the same write to 0x0000_0010 -> OKAY and read-back 0xA5A5A5A5.

Source files
------------

// File: rtl/ahb_slave_pkg.sv
// Shared encodings for the memory-backed AHB responder: FSM states, response codes
// and the wait-state counter width.
package ahb_slave_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    DATA = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ahb_slave_regfile.sv
// Word array with one synchronous write port and one synchronous read port.
// Deliberately unreset so synthesis can map it onto RAM.
module ahb_slave_regfile #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB single-transfer slave backed by a word array, with wait states and a two-cycle
// ERROR response. Optional read-only low region enabled by AHB_SLV_RO_REGION_EN.
//
// Handshake: a transfer is accepted in IDLE when hsel & hready are high at a rising
// edge; the slave then holds hreadyout low until the completing cycle, in which
// hreadyout=1 and hresp/hrdata are valid. Requests seen while busy are ignored.
module ahb_slave_mem
  import ahb_slave_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
`ifdef AHB_SLV_RO_REGION_EN
  ,
  parameter int          RO_WORDS    = 4
`endif
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output state_t      dbg_state
);

  state_t                state, state_nx;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0]     idx_q;
  logic                  write_q;
  logic                  rd_valid;
  logic [31:0]           rd_data;

  logic [ADDR_W-1:0]     bus_idx;
  logic                  accept;
  logic                  misaligned;
  logic                  out_of_win;
  logic                  ro_hit;
  logic                  acc_err;
  logic                  cur_write;
  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_W-1:0]     rd_addr;

  assign bus_idx    = haddr[ADDR_W+1:2];
  assign accept     = hsel & hready & (state == IDLE);
  assign misaligned = |haddr[1:0];
  assign out_of_win = haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];

`ifdef AHB_SLV_RO_REGION_EN
  assign ro_hit = hwrite & (int'(bus_idx) < RO_WORDS);
`else
  assign ro_hit = 1'b0;
`endif

  assign acc_err = misaligned | out_of_win | ro_hit;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_err)               state_nx = ERR1;
          else if (WAIT_STATES == 0) state_nx = DATA;
          else                       state_nx = WAIT;
        end
      end
      WAIT:    if (wait_cnt == '0) state_nx = DATA;
      DATA:    state_nx = IDLE;
      ERR1:    state_nx = ERR2;
      ERR2:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      WAIT: hreadyout = 1'b0;
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        idx_q   <= bus_idx;
        write_q <= hwrite;
        if (!acc_err && WAIT_STATES > 0)
          wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // The read must launch on the edge that enters DATA; with no wait states that is
  // the accept edge itself, so the address comes straight from the bus.
  assign cur_write = (state == IDLE) ? hwrite : write_q;
  assign rd_addr   = (state == IDLE) ? bus_idx : idx_q;
  assign rd_en     = (state_nx == DATA) && (state != DATA) && !cur_write;
  assign wr_en     = (state == DATA) && write_q;

  // rd_valid gives hrdata its reset value and the zero forced on ERR2 entry,
  // since the array output register itself is unreset.
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn)                               rd_valid <= 1'b0;
    else if (rd_en)                            rd_valid <= 1'b1;
    else if (state == ERR1 && state_nx == ERR2) rd_valid <= 1'b0;
  end

  assign hrdata    = rd_valid ? rd_data : 32'h0;
  assign dbg_state = state;

  ahb_slave_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_regfile (
    .clk  (hclk),
    .we   (wr_en),
    .waddr(idx_q),
    .wdata(hwdata),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule
